// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master.
// State encoding, address-field positions and the timeout counter width.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int SLV_IDX_LSB = 6;
   localparam int SLV_IDX_W   = 2;
   localparam int ADDR_HI_LSB = 8;
   localparam int TO_CNT_W    = 8;

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin picker: rr_ptr wins when it is requesting, otherwise the other side.
// Purely combinational; valid is high whenever any request is present.
module apb_rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr_ptr,
   output logic       winner,
   output logic       valid
);

   assign winner = req[rr_ptr] ? rr_ptr : ~rr_ptr;
   assign valid  = |req;

endmodule

// File: rtl/apb_arb_master.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing and slave decode.
// Optional ACCESS-phase timeout is built when APB_TIMEOUT_EN is defined.
module apb_arb_master
   import apb_arb_pkg::*;
#(
   parameter int AW        = 64,
   parameter int DW        = 64,
   parameter int NSLV      = 4,
   parameter int TO_CYCLES = 16
) (
   input  logic            PCLK,
   input  logic            PRESETn,
   input  logic [1:0]      req,
   input  logic [1:0]      req_write,
   input  logic [2*AW-1:0] req_addr,
   input  logic [2*DW-1:0] req_wdata,
   output logic [1:0]      gnt,
   output logic [1:0]      done,
   output logic [DW-1:0]   rdata,
   output logic            err,
   output logic [NSLV-1:0] PSEL,
   output logic            PENABLE,
   output logic            PWRITE,
   output logic [AW-1:0]   PADDR,
   output logic [DW-1:0]   PWDATA,
   input  logic [DW-1:0]   PRDATA,
   input  logic            PREADY,
   input  logic            PSLVERR
);

   apb_state_e          state_q, state_d;
   logic [NSLV-1:0]     psel_q, psel_d;
   logic                penable_q, penable_d;
   logic                pwrite_q, pwrite_d;
   logic [AW-1:0]       paddr_q, paddr_d;
   logic [DW-1:0]       pwdata_q, pwdata_d;
   logic [DW-1:0]       rdata_q, rdata_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          done_q, done_d;
   logic                err_q, err_d;
   logic                rr_q, rr_d;
   logic                win_q, win_d;
   logic                miss_q, miss_d;

   logic [1:0]          req_eff;
   logic                arb_win, arb_valid;
   logic [AW-1:0]       lane_addr;
   logic [SLV_IDX_W-1:0] lane_idx;
   logic                lane_hit;
   logic                abort;

   // A requester whose done is pulsing this cycle has not yet dropped req; keep it out.
   assign req_eff = req & ~done_q;

   apb_rr_arb2 u_arb (
      .req    (req_eff),
      .rr_ptr (rr_q),
      .winner (arb_win),
      .valid  (arb_valid)
   );

   assign lane_addr = arb_win ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
   assign lane_idx  = lane_addr[SLV_IDX_LSB +: SLV_IDX_W];
   assign lane_hit  = ((lane_addr >> ADDR_HI_LSB) == '0) && (int'(lane_idx) < NSLV);

`ifdef APB_TIMEOUT_EN
   logic [TO_CNT_W-1:0] to_q, to_d, to_inc;

   assign to_inc = to_q + TO_CNT_W'(1);
   assign abort  = (state_q == ACCESS) && !PREADY && (to_inc == TO_CNT_W'(TO_CYCLES));

   always_comb begin
      to_d = to_q;
      if (state_q == SETUP)
         to_d = '0;
      else if (state_q == ACCESS && !PREADY)
         to_d = to_inc;
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) to_q <= '0;
      else          to_q <= to_d;
   end
`else
   assign abort = (TO_CYCLES < 0);
`endif

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      rdata_d   = rdata_q;
      gnt_d     = 2'b00;
      done_d    = 2'b00;
      err_d     = 1'b0;
      rr_d      = rr_q;
      win_d     = win_q;
      miss_d    = miss_q;
      unique case (state_q)
         IDLE: begin
            if (miss_q) begin
               // Decode miss: answer one cycle after the grant without touching the bus.
               miss_d       = 1'b0;
               done_d[win_q] = 1'b1;
               err_d        = 1'b1;
               rr_d         = ~win_q;
            end else if (arb_valid) begin
               win_d          = arb_win;
               gnt_d[arb_win] = 1'b1;
               pwrite_d       = req_write[arb_win];
               paddr_d        = lane_addr;
               pwdata_d       = arb_win ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
               if (lane_hit) begin
                  state_d = SETUP;
                  psel_d  = NSLV'(1) << lane_idx;
               end else begin
                  miss_d = 1'b1;
               end
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            state_d   = ACCESS;
         end
         ACCESS: begin
            if (PREADY || abort) begin
               psel_d        = '0;
               penable_d     = 1'b0;
               done_d[win_q] = 1'b1;
               err_d         = abort ? 1'b1 : PSLVERR;
               if (PREADY && !pwrite_q)
                  rdata_d = PRDATA;
               rr_d    = ~win_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q   <= IDLE;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         rdata_q   <= '0;
         gnt_q     <= 2'b00;
         done_q    <= 2'b00;
         err_q     <= 1'b0;
         rr_q      <= 1'b0;
         win_q     <= 1'b0;
         miss_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         rdata_q   <= rdata_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rr_q      <= rr_d;
         win_q     <= win_d;
         miss_q    <= miss_d;
      end
   end

   assign gnt     = gnt_q;
   assign done    = done_q;
   assign rdata   = rdata_q;
   assign err     = err_q;
   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign PWRITE  = pwrite_q;
   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Self-checking bench for apb_arb_master: table of single transfers, then reset,
// round-robin and (with APB_TIMEOUT_EN) timeout sequences against a small slave model.
module tb_apb_arb_master;

   logic         PCLK;
   logic         PRESETn;
   logic [1:0]   req;
   logic [1:0]   req_write;
   logic [127:0] req_addr;
   logic [127:0] req_wdata;
   logic [1:0]   gnt;
   logic [1:0]   done;
   logic [63:0]  rdata;
   logic         err;
   logic [3:0]   PSEL;
   logic         PENABLE;
   logic         PWRITE;
   logic [63:0]  PADDR;
   logic [63:0]  PWDATA;
   logic [63:0]  PRDATA;
   logic         PREADY;
   logic         PSLVERR;

   int total = 0;
   int bad   = 0;

   // slave model controls
   bit          stuck   = 0;
   int          wait_cyc = 0;
   bit          slverr_v = 0;
   int          acc_cnt;
   logic [63:0] mem [0:255];

   logic [1:0]  exp_q[$];

   apb_arb_master dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .req       (req),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .done      (done),
      .rdata     (rdata),
      .err       (err),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   // clock / reset
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // memory slave cluster: 4 slaves x 64 words, word index = PADDR[7:0]
   assign PREADY  = !stuck && (acc_cnt >= wait_cyc);
   assign PSLVERR = slverr_v;
   assign PRDATA  = mem[PADDR[7:0]];

   always @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         acc_cnt <= 0;
      end else begin
         if (PSEL != 4'b0 && PENABLE) acc_cnt <= acc_cnt + 1;
         else                          acc_cnt <= 0;
         if (PSEL != 4'b0 && PENABLE && PREADY && PWRITE)
            mem[PADDR[7:0]] <= PWDATA;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // driver: one request on lane r, observed until its done pulse (bounded)
   task automatic run_xfer(input bit r, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                           output bit got, output int lat, output int pen, output logic [3:0] pseen,
                           output bit stable, output logic rerr, output logic [63:0] rd);
      logic [63:0] a0;
      bit first;
      got = 0; lat = 0; pen = 0; pseen = 4'b0; stable = 1; first = 1; rerr = 1'b0; rd = '0; a0 = '0;
      req_write[r] = wr;
      req_addr[r*64 +: 64]  = a;
      req_wdata[r*64 +: 64] = wd;
      req[r] = 1'b1;
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge PCLK);
         lat++;
         pseen |= PSEL;
         if (PENABLE) begin
            pen++;
            if (first) begin
               a0 = PADDR;
               first = 0;
            end else if (PADDR !== a0 || PWRITE !== wr || PWDATA !== wd) begin
               stable = 0;
            end
         end
         if (done[r]) begin
            got  = 1;
            rerr = err;
            rd   = rdata;
            req[r] = 1'b0;
         end
      end
      req[r] = 1'b0;
   endtask

   // both requesters at once: lane0 reads 0x48, lane1 reads 0xC0
   task automatic both_pair(input bit first_win);
      int cyc, t_d1, t_s2, rises, ndone, overlap;
      logic psel_prev;
      logic [1:0] e;
      cyc = 0; t_d1 = -100; t_s2 = 0; rises = 0; ndone = 0; overlap = 0; psel_prev = 1'b0;
      exp_q.push_back({1'b0, first_win});
      exp_q.push_back({1'b0, ~first_win});
      req_write = 2'b00;
      req_addr  = {64'h0000_0000_0000_00C0, 64'h0000_0000_0000_0048};
      req = 2'b11;
      while (ndone < 2 && cyc < 40) begin
         @(negedge PCLK);
         cyc++;
         if (gnt != 2'b00 && done != 2'b00) overlap++;
         if (PSEL != 4'b0 && !psel_prev) begin
            rises++;
            if (rises == 2) t_s2 = cyc;
         end
         psel_prev = (PSEL != 4'b0);
         for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
               e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'd3;
               chk("rr_order", 64'(i), 64'(e));
               chk("rr_rdata", rdata, (i == 0) ? 64'hDEAD_BEEF : 64'h1234_5678);
               if (ndone == 0) t_d1 = cyc;
               ndone++;
               req[i] = 1'b0;
            end
         end
      end
      req = 2'b00;
      chk("both_done", 64'(ndone), 64'd2);
      chk("b2b_gap", 64'(t_s2 - t_d1), 64'd1);
      chk("gnt_done_overlap", 64'(overlap), 64'd0);
      exp_q.delete();
      @(negedge PCLK);
   endtask

   typedef struct {
      bit          r;
      bit          wr;
      logic [63:0] addr;
      logic [63:0] wdata;
      int          wt;
      bit          slverr;
      bit          exp_err;
      logic [63:0] exp_rdata;
      logic [3:0]  exp_psel;
      int          exp_lat;
      int          exp_pen;
   } vec_t;

   vec_t vecs [8];

   initial begin : main
      bit got, stable;
      int lat, pen, nd;
      logic [3:0] pseen;
      logic rerr;
      logic [63:0] rd;

      vecs[0] = '{1'b0, 1'b1, 64'h48,          64'hDEAD_BEEF, 0, 1'b0, 1'b0, 64'h0,         4'b0010, 3, 1};
      vecs[1] = '{1'b0, 1'b0, 64'h48,          64'h0,         0, 1'b0, 1'b0, 64'hDEAD_BEEF, 4'b0010, 3, 1};
      vecs[2] = '{1'b1, 1'b1, 64'hC0,          64'h1234_5678, 0, 1'b0, 1'b0, 64'hDEAD_BEEF, 4'b1000, 3, 1};
      vecs[3] = '{1'b1, 1'b0, 64'h100,         64'h0,         0, 1'b0, 1'b1, 64'hDEAD_BEEF, 4'b0000, 2, 0};
      vecs[4] = '{1'b0, 1'b1, 64'h04,          64'hA5A5,      5, 1'b1, 1'b1, 64'hDEAD_BEEF, 4'b0001, 8, 6};
      vecs[5] = '{1'b1, 1'b0, 64'hC0,          64'h0,         0, 1'b0, 1'b0, 64'h1234_5678, 4'b1000, 3, 1};
      vecs[6] = '{1'b0, 1'b0, 64'h04,          64'h0,         0, 1'b0, 1'b0, 64'hA5A5,      4'b0001, 3, 1};
      vecs[7] = '{1'b0, 1'b0, 64'h1_0000_0048, 64'h0,         0, 1'b0, 1'b1, 64'hA5A5,      4'b0000, 2, 0};

      PRESETn = 1'b0;
      req = 2'b00; req_write = 2'b00; req_addr = '0; req_wdata = '0;
      repeat (2) @(negedge PCLK);
      chk("rst_psel", 64'(PSEL), 64'd0);
      chk("rst_penable", 64'(PENABLE), 64'd0);
      chk("rst_gnt_done_err", 64'({gnt, done, err}), 64'd0);
      chk("rst_rdata", rdata, 64'd0);
      chk("rst_paddr", PADDR, 64'd0);
      PRESETn = 1'b1;
      @(negedge PCLK);

      for (int v = 0; v < 8; v++) begin
         wait_cyc = vecs[v].wt;
         slverr_v = vecs[v].slverr;
         run_xfer(vecs[v].r, vecs[v].wr, vecs[v].addr, vecs[v].wdata, got, lat, pen, pseen, stable, rerr, rd);
         chk($sformatf("v%0d_done", v), 64'(got), 64'd1);
         chk($sformatf("v%0d_err", v), 64'(rerr), 64'(vecs[v].exp_err));
         chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
         chk($sformatf("v%0d_psel", v), 64'(pseen), 64'(vecs[v].exp_psel));
         chk($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
         chk($sformatf("v%0d_penable_cycles", v), 64'(pen), 64'(vecs[v].exp_pen));
         chk($sformatf("v%0d_bus_stable", v), 64'(stable), 64'd1);
         wait_cyc = 0;
         slverr_v = 0;
         @(negedge PCLK);
      end

      // reset while requester 1 sits in ACCESS (rr_ptr is 1 here)
      stuck = 1;
      req_write[1] = 1'b1;
      req_addr[127:64]  = 64'h48;
      req_wdata[127:64] = 64'h5555;
      req[1] = 1'b1;
      for (int c = 0; c < 10 && !PENABLE; c++) @(negedge PCLK);
      chk("reach_access", 64'(PENABLE), 64'd1);
      @(negedge PCLK);
      #2 PRESETn = 1'b0;
      #1;
      chk("async_rst_psel", 64'(PSEL), 64'd0);
      chk("async_rst_penable", 64'(PENABLE), 64'd0);
      chk("async_rst_gnt_done_err", 64'({gnt, done, err}), 64'd0);
      req = 2'b00;
      stuck = 0;
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
      nd = 0;
      repeat (3) begin
         @(negedge PCLK);
         if (done != 2'b00) nd++;
      end
      chk("no_done_after_rst", 64'(nd), 64'd0);

      // rr_ptr back to 0: requester 0 first, then 1
      both_pair(1'b0);
      run_xfer(1'b0, 1'b0, 64'h48, 64'h0, got, lat, pen, pseen, stable, rerr, rd);
      chk("solo_done", 64'(got), 64'd1);
      chk("solo_rdata", rd, 64'hDEAD_BEEF);
      @(negedge PCLK);
      both_pair(1'b1);

`ifdef APB_TIMEOUT_EN
      stuck = 1;
      run_xfer(1'b0, 1'b0, 64'h08, 64'h0, got, lat, pen, pseen, stable, rerr, rd);
      chk("to_done", 64'(got), 64'd1);
      chk("to_err", 64'(rerr), 64'd1);
      chk("to_penable_cycles", 64'(pen), 64'd16);
      chk("to_latency", 64'(lat), 64'd18);
      chk("to_rdata", rd, 64'hDEAD_BEEF);
      stuck = 0;
      @(negedge PCLK);
      run_xfer(1'b1, 1'b0, 64'hC0, 64'h0, got, lat, pen, pseen, stable, rerr, rd);
      chk("after_to_done", 64'(got), 64'd1);
      chk("after_to_err", 64'(rerr), 64'd0);
      chk("after_to_rdata", rd, 64'h1234_5678);
      chk("after_to_latency", 64'(lat), 64'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
